// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port, byte-write-enabled RAM between the instruction-fetch
//   port (IF, read-only) and the load/store port (LS). At most one grant per
//   cycle; the RAM's registered read data is steered back to the port that won
//   in the previous cycle, together with a one-cycle valid strobe.
//
//   Build option ARB_ROUND_ROBIN_EN:
//     undefined (default) - LS has priority; IF is forced through after it has
//                           been denied MAX_WAIT consecutive cycles.
//     defined             - contested cycles alternate between the ports; the
//                           port not granted most recently wins. MAX_WAIT unused.
//
//   Reset is synchronous and active-low. While rst_n_i is low every output is
//   forced idle, which also discards an access granted in the cycle just
//   before reset.

module ram_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [3:0]  ls_wen_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_wen_o,
  input  logic [31:0] ram_rdata_i
);

  // Owner of the access whose read data is on ram_rdata_i this cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LS   = 2'd2;

  logic [1:0]  owner_q;
  logic [31:0] last_addr_q;
  logic        if_win;
  logic        ls_win;

`ifdef ARB_ROUND_ROBIN_EN

  // 1 when IF took the most recent grant. Resets to 1 so that LS wins the
  // first contested cycle after reset.
  logic last_win_if_q;

  // Round-robin winner selection; a lone requester always wins.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (rst_n_i) begin
      if (if_req_i && ls_req_i) begin
        if_win = ~last_win_if_q;
        ls_win = last_win_if_q;
      end else begin
        if_win = if_req_i;
        ls_win = ls_req_i;
      end
    end
  end

  // Remember which port won last; only an actual grant moves the pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_win_if_q <= 1'b1;
    end else if (if_win) begin
      last_win_if_q <= 1'b1;
    end else if (ls_win) begin
      last_win_if_q <= 1'b0;
    end
  end

`else

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Consecutive cycles IF has been requesting without a grant.
  logic [3:0] starve_cnt_q;
  logic       if_forced;

  assign if_forced = (starve_cnt_q == MAX_WAIT_C);

  // LS-priority selection, overridden once IF has waited MAX_WAIT cycles.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (rst_n_i) begin
      if_win = if_req_i & (~ls_req_i | if_forced);
      ls_win = ls_req_i & ~if_win;
    end
  end

  // Count IF denials; clear on IF grant or when IF drops its request; saturate.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      starve_cnt_q <= 4'd0;
    end else if (if_req_i && !if_win) begin
      if (starve_cnt_q < MAX_WAIT_C) begin
        starve_cnt_q <= starve_cnt_q + 4'd1;
      end
    end else begin
      starve_cnt_q <= 4'd0;
    end
  end

`endif

  assign if_gnt_o = if_win;
  assign ls_gnt_o = ls_win;

  // Steer the winner onto the RAM; with no grant the address parks on the last
  // granted one and nothing is written.
  always_comb begin
    ram_addr_o  = rst_n_i ? last_addr_q : 32'd0;
    ram_wdata_o = 32'd0;
    ram_wen_o   = 4'd0;
    if (if_win) begin
      ram_addr_o = if_addr_i;
    end else if (ls_win) begin
      ram_addr_o  = ls_addr_i;
      ram_wdata_o = ls_wdata_i;
      ram_wen_o   = ls_wen_i;
    end
  end

  // Record who owns next cycle's read data and the address to park on.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      owner_q     <= OWN_NONE;
      last_addr_q <= 32'd0;
    end else begin
      if (if_win) begin
        owner_q     <= OWN_IF;
        last_addr_q <= if_addr_i;
      end else if (ls_win) begin
        owner_q     <= OWN_LS;
        last_addr_q <= ls_addr_i;
      end else begin
        owner_q     <= OWN_NONE;
      end
    end
  end

  // Completion strobes and read data, forced idle while reset is asserted.
  always_comb begin
    if_rvalid_o = rst_n_i & (owner_q == OWN_IF);
    ls_rvalid_o = rst_n_i & (owner_q == OWN_LS);
    if_rdata_o  = if_rvalid_o ? ram_rdata_i : 32'd0;
    ls_rdata_o  = ls_rvalid_o ? ram_rdata_i : 32'd0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter (default LS-priority build): a directed vector
// table, a starvation-pattern sequence and a randomized run, all checked against
// a cycle-level reference model of the arbitration rules plus a small RAM model.

module tb_ram_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_wen;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_wen;

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_wen_i(ls_wen),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wen_o(ram_wen),
    .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // 64-word RAM with registered read-before-write data and byte lanes.
  logic [31:0] mem [0:63];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    ram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  typedef struct {
    bit          rst_n;
    bit          if_req;
    logic [31:0] if_addr;
    bit          ls_req;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wen;
    bit          e_if_gnt;
    bit          e_ls_gnt;
    bit          e_if_rv;
    bit          e_ls_rv;
    logic [3:0]  e_wen;
    bit          chk_rd;
    logic [31:0] e_ls_rdata;
  } vec_t;

  // Reference model state: 0 = nobody, 1 = IF, 2 = LS owns next read data.
  int          ref_wait  = 0;
  int          ref_owner = 0;
  logic [31:0] ref_last  = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check before the rising edge,
  // then advance the reference model to the state after the rising edge.
  task automatic run_cycle(input vec_t v, input bit use_exp, output bit g_if, output bit g_ls);
    bit          m_if_w, m_ls_w, m_if_rv, m_ls_rv;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wen;
    @(negedge clk);
    rst_n = v.rst_n; if_req = v.if_req; if_addr = v.if_addr;
    ls_req = v.ls_req; ls_addr = v.ls_addr; ls_wdata = v.ls_wdata; ls_wen = v.ls_wen;
    #1;
    m_if_w = v.rst_n && v.if_req && (!v.ls_req || ref_wait >= MAX_WAIT);
    m_ls_w = v.rst_n && v.ls_req && !m_if_w;
    m_addr  = !v.rst_n ? 32'h0 : m_if_w ? v.if_addr : m_ls_w ? v.ls_addr : ref_last;
    m_wen   = m_ls_w ? v.ls_wen : 4'h0;
    m_wdata = m_ls_w ? v.ls_wdata : 32'h0;
    m_if_rv = v.rst_n && ref_owner == 1;
    m_ls_rv = v.rst_n && ref_owner == 2;
    chk("if_gnt", 32'(if_gnt), 32'(m_if_w));
    chk("ls_gnt", 32'(ls_gnt), 32'(m_ls_w));
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_wen", 32'(ram_wen), 32'(m_wen));
    if (!m_if_w) chk("ram_wdata", ram_wdata, m_wdata);
    chk("if_rvalid", 32'(if_rvalid), 32'(m_if_rv));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(m_ls_rv));
    chk("if_rdata", if_rdata, m_if_rv ? ram_rdata : 32'h0);
    chk("ls_rdata", ls_rdata, m_ls_rv ? ram_rdata : 32'h0);
    if (use_exp) begin
      chk("tbl_gnt", {30'h0, if_gnt, ls_gnt}, {30'h0, v.e_if_gnt, v.e_ls_gnt});
      chk("tbl_rvalid", {30'h0, if_rvalid, ls_rvalid}, {30'h0, v.e_if_rv, v.e_ls_rv});
      chk("tbl_wen", 32'(ram_wen), 32'(v.e_wen));
      if (v.chk_rd) chk("tbl_ls_rdata", ls_rdata, v.e_ls_rdata);
    end
    if (!v.rst_n) begin
      ref_wait = 0; ref_owner = 0; ref_last = 32'h0;
    end else begin
      ref_owner = m_if_w ? 1 : m_ls_w ? 2 : 0;
      if (m_if_w) ref_last = v.if_addr;
      else if (m_ls_w) ref_last = v.ls_addr;
      if (v.if_req && !m_if_w) ref_wait = (ref_wait < MAX_WAIT) ? ref_wait + 1 : ref_wait;
      else ref_wait = 0;
    end
    g_if = m_if_w;
    g_ls = m_ls_w;
  endtask

  function automatic vec_t mk(bit r, bit ir, logic [31:0] ia, bit lr, logic [31:0] la,
                              logic [31:0] lw, logic [3:0] le, bit eig, bit elg,
                              bit eiv, bit elv, logic [3:0] ew, bit cr, logic [31:0] erd);
    vec_t v;
    v.rst_n = r; v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_addr = la;
    v.ls_wdata = lw; v.ls_wen = le; v.e_if_gnt = eig; v.e_ls_gnt = elg;
    v.e_if_rv = eiv; v.e_ls_rv = elv; v.e_wen = ew; v.chk_rd = cr; v.e_ls_rdata = erd;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    bit gi, gl;
    bit          ip, lp;
    logic [31:0] ia, la, lw;
    logic [3:0]  le;
    int deny, max_deny;
    vec_t v;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0;
    ls_addr = '0; ls_wdata = '0; ls_wen = '0;

    //           rst ifr ifaddr  lsr lsaddr  wdata         wen   ig lg iv lv ewen chk rdata
    tbl[0]  = mk(0, 1, 32'h00, 1, 32'h10, 32'h1111_1111, 4'hF, 0, 0, 0, 0, 4'h0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 32'h00, 1, 32'h10, 32'h1111_1111, 4'hF, 0, 0, 0, 0, 4'h0, 0, 32'h0);
    tbl[2]  = mk(0, 1, 32'h00, 1, 32'h10, 32'h1111_1111, 4'hF, 0, 0, 0, 0, 4'h0, 0, 32'h0);
    tbl[3]  = mk(1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 0, 0, 0, 0, 4'h0, 0, 32'h0);
    tbl[4]  = mk(1, 0, 32'h00, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 0, 4'hF, 0, 32'h0);
    tbl[5]  = mk(1, 0, 32'h00, 1, 32'h10, 32'h0,         4'h0, 0, 1, 0, 1, 4'h0, 0, 32'h0);
    tbl[6]  = mk(1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 0, 0, 0, 1, 4'h0, 1, 32'hDEAD_BEEF);
    tbl[7]  = mk(1, 1, 32'h00, 0, 32'h00, 32'h0,         4'h0, 1, 0, 0, 0, 4'h0, 0, 32'h0);
    tbl[8]  = mk(1, 1, 32'h04, 0, 32'h00, 32'h0,         4'h0, 1, 0, 1, 0, 4'h0, 0, 32'h0);
    tbl[9]  = mk(1, 1, 32'h08, 0, 32'h00, 32'h0,         4'h0, 1, 0, 1, 0, 4'h0, 0, 32'h0);
    tbl[10] = mk(1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 0, 0, 1, 0, 4'h0, 0, 32'h0);
    tbl[11] = mk(1, 0, 32'h00, 1, 32'h10, 32'h0,         4'h0, 0, 1, 0, 0, 4'h0, 0, 32'h0);
    tbl[12] = mk(0, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 0, 0, 0, 0, 4'h0, 0, 32'h0);
    tbl[13] = mk(1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 0, 0, 0, 0, 4'h0, 0, 32'h0);
    tbl[14] = mk(1, 0, 32'h00, 1, 32'h10, 32'h0,         4'h0, 0, 1, 0, 0, 4'h0, 0, 32'h0);
    tbl[15] = mk(1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 0, 0, 0, 1, 4'h0, 1, 32'hDEAD_BEEF);
    tbl[16] = mk(1, 1, 32'h20, 1, 32'h13, 32'hA5A5_5A5A, 4'h5, 0, 1, 0, 0, 4'h5, 0, 32'h0);
    tbl[17] = mk(1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 0, 0, 0, 1, 4'h0, 0, 32'h0);

    for (int i = 0; i < 18; i++) run_cycle(tbl[i], 1'b1, gi, gl);

    // Both ports requesting continuously: LS,LS,LS,LS,IF repeating.
    v = mk(1, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 32'h0);
    run_cycle(v, 1'b0, gi, gl);
    v = mk(1, 1, 32'h40, 1, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      run_cycle(v, 1'b0, gi, gl);
      chk("starve_pattern", {30'h0, if_gnt, ls_gnt}, (i % 5 == 4) ? 32'h2 : 32'h1);
    end

    // Randomized traffic honouring the hold-until-grant handshake.
    ip = 0; lp = 0; ia = '0; la = '0; lw = '0; le = '0;
    deny = 0; max_deny = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1; ia = $urandom & 32'hFF;
      end
      if (!lp && $urandom_range(0, 3) != 0) begin
        lp = 1; la = $urandom & 32'hFF; lw = $urandom;
        le = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      v = mk(($urandom_range(0, 59) != 0), ip, ia, lp, la, lw, le,
             0, 0, 0, 0, 4'h0, 0, 32'h0);
      run_cycle(v, 1'b0, gi, gl);
      if (v.rst_n && ip && !if_gnt) deny++;
      else deny = 0;
      if (deny > max_deny) max_deny = deny;
      if (gi) ip = 0;
      if (gl) lp = 0;
    end
    chk("if_max_wait_bounded", 32'(max_deny <= MAX_WAIT), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
